uart_tx_fifo: RTL

Parametrised UART transmitter with its own baud-rate generator, a FIFO on the input side and per-frame parity and stop-bit selection. Upstream logic pushes words through a valid/ready handshake, and the block serialises them LSB first on `tx_out`. Frames run back-to-back with no gap while the FIFO holds data. It sits between the system-clock datapath and the UART pin, and needs no external baud strobe.

---
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, internal baud generator and per-frame
// parity / stop-bit selection latched when each frame starts.
module uart_tx_fifo #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic                             clock,
   input  logic                             resetn,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [1:0]                       parity_mode,
   input  logic                             two_stop,
   input  logic                             tx_enable,
   output logic                             tx_out,
   output logic                             busy,
   output logic                             frame_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             fifo_full,
   output logic                             fifo_empty
);

   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW  = $clog2(DATA_WIDTH);

   localparam logic [CntW-1:0]  DepthC  = CntW'(FIFO_DEPTH);
   localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0]  IdxMax  = IdxW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   // FIFO storage and status
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  push, pop;

   // Transmitter state
   state_e                state_q, state_d;
   logic [BaudW-1:0]      baud_q, baud_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_bit_q, par_bit_d;
   logic                  par_en_q, par_en_d;
   logic                  two_stop_q, two_stop_d;
   logic                  stop2_q, stop2_d;
   logic                  done_q, done_d;
   logic                  bit_end, start_ok;

   assign push       = in_valid && !full_q;
   assign in_ready   = !full_q;
   assign fifo_count = count_q;
   assign fifo_full  = full_q;
   assign fifo_empty = empty_q;
   assign frame_done = done_q;

   assign bit_end  = (baud_q == BaudMax);
   assign start_ok = !empty_q && tx_enable;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == DepthC);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; pop marks every transition into StStart
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StStart;
               pop     = 1'b1;
            end
         end
         StStart: if (bit_end) state_d = StData;
         StData: begin
            if (bit_end && idx_q == IdxMax) state_d = par_en_q ? StParity : StStop;
         end
         StParity: if (bit_end) state_d = StStop;
         StStop: begin
            if (bit_end && (!two_stop_q || stop2_q)) begin
               if (start_ok) begin
                  state_d = StStart;
                  pop     = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != StIdle);
      unique case (state_q)
         StStart:  tx_out = 1'b0;
         StData:   tx_out = shift_q[0];
         StParity: tx_out = par_bit_q;
         default:  tx_out = 1'b1;
      endcase
   end

   // Datapath next state; frame configuration is captured only on pop
   always_comb begin
      baud_d     = (pop || state_q == StIdle || bit_end) ? '0 : baud_q + BaudW'(1);
      idx_d      = (state_q != StData) ? '0 : (bit_end ? idx_q + IdxW'(1) : idx_q);
      shift_d    = shift_q;
      par_bit_d  = par_bit_q;
      par_en_d   = par_en_q;
      two_stop_d = two_stop_q;
      if (pop) begin
         shift_d    = mem_q[rd_ptr_q];
         par_bit_d  = (^mem_q[rd_ptr_q]) ^ (parity_mode == 2'b10);
         par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
         two_stop_d = two_stop;
      end else if (state_q == StData && bit_end) begin
         shift_d = shift_q >> 1;
      end
      stop2_d = (state_q != StStop) ? 1'b0 : (stop2_q || bit_end);
      done_d  = (state_q == StStop) && (state_d != StStop);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         baud_q     <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         par_bit_q  <= 1'b0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         stop2_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         baud_q     <= baud_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         par_bit_q  <= par_bit_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         stop2_q    <= stop2_d;
         done_q     <= done_d;
      end
   end

endmodule
